mem_preload_ctrl: RTL and testbench

//  Boot-time loader sitting directly upstream of top_riscv_cpu. Accepts a little-endian

---
 rtl/mem_preload_ctrl_pkg.sv | 17 +
 rtl/mem_preload_ctrl_if.sv | 21 ++
 rtl/mem_preload_ctrl_packer.sv | 43 ++++
 rtl/mem_preload_ctrl.sv | 103 ++++++++++
 tb/tb_mem_preload_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_preload_ctrl_pkg.sv
// Shared types and helpers for the boot-time memory preloader.
package mem_preload_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StRun
  } state_e;

  localparam int unsigned BytesPerWord = 4;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] index);
    return base + {index[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/mem_preload_ctrl_if.sv
// Host byte stream plus CPU external-memory write bus; master is the loader side.
interface mem_preload_ctrl_if;

  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;

  modport master (
    input  in_valid, in_byte,
    output in_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr
  );

  modport slave (
    output in_valid, in_byte,
    input  in_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr
  );

endinterface

// File: rtl/mem_preload_ctrl_packer.sv
// Packs little-endian bytes into 32-bit words; word_o already includes the byte being accepted.
module mem_preload_ctrl_packer
  import mem_preload_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      word_d     = '0;
    end else if (shift_en_i) begin
      word_d[{byte_cnt_q, 3'b000} +: 8] = byte_i;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  // Combinational so the FSM can register the finished word on the same edge as the last byte.
  assign word_full_o = shift_en_i && !clear_i && (byte_cnt_q == 2'(BytesPerWord - 1));
  assign word_o      = word_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

endmodule

// File: rtl/mem_preload_ctrl.sv
// Boot loader: streams host bytes into CPU data memory while holding the CPU in reset.
module mem_preload_ctrl
  import mem_preload_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_words,
  mem_preload_ctrl_if.master  bus,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] index_q;
  logic [CNT_W-1:0] index_inc;
  logic             legal;
  logic             accept;
  logic             xfer;
  logic             word_full;
  logic [31:0]      word;

  assign legal     = (num_words != '0) && (32'(num_words) <= MAX_WORDS);
  assign accept    = start && legal && ((state_q == StIdle) || (state_q == StRun));
  assign xfer      = bus.in_valid && bus.in_ready;
  assign index_inc = index_q + CNT_W'(1);

  mem_preload_ctrl_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (accept),
    .shift_en_i  (xfer),
    .byte_i      (bus.in_byte),
    .word_o      (word),
    .word_full_o (word_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= StIdle;
      count_q           <= '0;
      index_q           <= '0;
      cpu_reset         <= 1'b1;
      bus.Ext_MemWrite  <= 1'b0;
      bus.Ext_WriteData <= '0;
      bus.Ext_DataAdr   <= BASE_ADDR;
      bus.in_ready      <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      bus.Ext_MemWrite <= 1'b0;
      unique case (state_q)
        StIdle, StRun: begin
          // CPU is released one cycle after entering RUN; a legal start re-asserts reset.
          if (state_q == StRun) cpu_reset <= 1'b0;
          if (start) begin
            if (legal) begin
              state_q      <= StRecv;
              count_q      <= num_words;
              index_q      <= '0;
              cpu_reset    <= 1'b1;
              busy         <= 1'b1;
              done         <= 1'b0;
              err          <= 1'b0;
              bus.in_ready <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StRecv: begin
          if (word_full) begin
            state_q           <= StWrite;
            bus.in_ready      <= 1'b0;
            bus.Ext_MemWrite  <= 1'b1;
            bus.Ext_WriteData <= word;
            bus.Ext_DataAdr   <= word_addr(BASE_ADDR, 32'(index_q));
          end
        end
        StWrite: begin
          index_q <= index_inc;
          if (index_inc == count_q) begin
            state_q <= StRun;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_q      <= StRecv;
            bus.in_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_preload_ctrl.sv
// Directed-plus-random bench for mem_preload_ctrl against a word-packing reference model.
module tb_mem_preload_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned MAXW  = 64;
  localparam int unsigned CNT_W = 16;

  typedef logic [7:0] bq_t[$];

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_words = '0;
  logic             cpu_reset, busy, done, err;

  mem_preload_ctrl_if bus ();

  mem_preload_ctrl #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wr_adr[$];
  logic [31:0] wr_dat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Collect every write strobe; a write must never happen with the CPU running or ready high.
  always @(negedge clk) begin
    if (bus.Ext_MemWrite === 1'b1) begin
      wr_adr.push_back(bus.Ext_DataAdr);
      wr_dat.push_back(bus.Ext_WriteData);
      chk("strobe_cpu_held", {31'd0, cpu_reset}, 32'd1);
      chk("strobe_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
  end

  function automatic bq_t rand_bytes(input int nb);
    bq_t q;
    for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic logic [31:0] model_word(input bq_t q, input int i);
    return {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
  endfunction

  task automatic pulse_start(input int n);
    @(negedge clk);
    start     = 1'b1;
    num_words = CNT_W'(n);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send(input bq_t q, input bit bp);
    int  idx = 0;
    int  cyc = 0;
    int  budget = 20 * q.size() + 20;
    bit  v;
    while (idx < q.size() && cyc < budget) begin
      @(negedge clk);
      cyc++;
      v = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_valid = v;
      bus.in_byte  = v ? q[idx] : 8'($urandom);
      if (v && bus.in_ready === 1'b1) idx++;
    end
    chk("bytes_sent", idx, q.size());
  endtask

  // Last byte taken at edge N: strobe visible after N, done after N+1, CPU released after N+2.
  task automatic finish_load(input bq_t q);
    int n = q.size() / 4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("last_strobe", {31'd0, bus.Ext_MemWrite}, 32'd1);
    chk("ready_in_write", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("done_set", {31'd0, done}, 32'd1);
    chk("busy_clr", {31'd0, busy}, 32'd0);
    chk("cpu_held_n1", {31'd0, cpu_reset}, 32'd1);
    @(negedge clk);
    chk("cpu_released", {31'd0, cpu_reset}, 32'd0);
    chk("n_writes", wr_adr.size(), n);
    for (int i = 0; i < n && i < wr_adr.size(); i++) begin
      chk("wr_addr", wr_adr[i], BASE + 32'(4 * i));
      chk("wr_data", wr_dat[i], model_word(q, i));
    end
  endtask

  task automatic load(input bq_t q, input bit bp);
    wr_adr.delete();
    wr_dat.delete();
    pulse_start(q.size() / 4);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("start_cpu_held", {31'd0, cpu_reset}, 32'd1);
    chk("start_err_clr", {31'd0, err}, 32'd0);
    send(q, bp);
    finish_load(q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t b;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_memwrite", {31'd0, bus.Ext_MemWrite}, 32'd0);
    chk("rst_adr", bus.Ext_DataAdr, BASE);
    chk("rst_wdata", bus.Ext_WriteData, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    reset = 1'b1;

    // Fixed two-word load, with explicit word values
    b = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load(b, 1'b0);
    chk("fixed_w0", model_word(b, 0), 32'h00A0_0513);
    chk("fixed_w1", model_word(b, 1), 32'hDEAD_BEEF);

    // Random backpressure loads (each a reload from RUN)
    load(rand_bytes(12), 1'b1);
    load(rand_bytes(20), 1'b1);

    // Illegal starts while running: err set, CPU keeps running, no writes
    wr_adr.delete();
    wr_dat.delete();
    pulse_start(0);
    chk("ill0_err", {31'd0, err}, 32'd1);
    chk("ill0_cpu_run", {31'd0, cpu_reset}, 32'd0);
    chk("ill0_done", {31'd0, done}, 32'd1);
    pulse_start(MAXW + 1);
    chk("ill_max_err", {31'd0, err}, 32'd1);
    chk("ill_max_busy", {31'd0, busy}, 32'd0);
    chk("ill_max_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("ill_no_strobe", wr_adr.size(), 0);
    load(rand_bytes(4), 1'b1);

    // Reset after 6 of 8 bytes
    wr_adr.delete();
    wr_dat.delete();
    pulse_start(2);
    send(rand_bytes(6), 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_cpu", {31'd0, cpu_reset}, 32'd1);
    chk("mid_rst_memwrite", {31'd0, bus.Ext_MemWrite}, 32'd0);
    chk("mid_rst_adr", bus.Ext_DataAdr, BASE);
    chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("mid_rst_flags", {29'd0, busy, done, err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst_one_write", wr_adr.size(), 1);
    pulse_start(0);
    chk("idle_ill_err", {31'd0, err}, 32'd1);
    chk("idle_ill_busy", {31'd0, busy}, 32'd0);
    chk("idle_ill_cpu", {31'd0, cpu_reset}, 32'd1);
    load(rand_bytes(4), 1'b0);

    // Reload from RUN with a start pulse during RECV that must be ignored
    b = rand_bytes(4);
    wr_adr.delete();
    wr_dat.delete();
    pulse_start(1);
    chk("reload_cpu_held", {31'd0, cpu_reset}, 32'd1);
    chk("reload_done_clr", {31'd0, done}, 32'd0);
    send(b[0:1], 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    pulse_start(3);
    chk("busy_start_busy", {31'd0, busy}, 32'd1);
    chk("busy_start_ready", {31'd0, bus.in_ready}, 32'd1);
    send(b[2:3], 1'b0);
    finish_load(b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
